// File: rtl/alu_pkg.sv
// Shared types for the multi-bank ALU: command/response codes, packet layouts and bank FSM states.
// Build option ALU_SATURATE_EN (see alu_bank) does not change any type here.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2,
    INV = 2'd3
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    UNDERFLOW   = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t    command;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } input_packet_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    response_names_t   response;
  } output_packet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } bank_state_t;

endpackage

// File: rtl/alu_bank.sv
// One independent ALU bank: IDLE/BUSY/RESPOND FSM, captured operands and registered result.
// Define ALU_SATURATE_EN to clamp ADD overflow to all-ones and SUB underflow to zero.
module alu_bank
  import alu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  input_packet_t  req_i,
  output output_packet_t rsp_o
);

  // RESPOND is entered after LATENCY-1 cycles in BUSY, so the last count value is LATENCY-2.
  localparam logic [3:0] CNT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  bank_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  command_names_t    cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] data_q, data_d;
  response_names_t   resp_q, resp_d;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] res_data;
  response_names_t   res_code;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W:0] s);
`ifdef ALU_SATURATE_EN
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
`else
    return s[DATA_W-1:0];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W:0] d);
`ifdef ALU_SATURATE_EN
    return d[DATA_W] ? '0 : d[DATA_W-1:0];
`else
    return d[DATA_W-1:0];
`endif
  endfunction

  assign sum  = {1'b0, op1_q} + {1'b0, op2_q};
  assign diff = {1'b0, op1_q} - {1'b0, op2_q};

  always_comb begin
    res_data = '0;
    res_code = NO_RESPONSE;
    case (cmd_q)
      ADD: begin
        res_data = sat_add(sum);
        res_code = sum[DATA_W] ? OVERFLOW : SUCCESS;
      end
      SUB: begin
        res_data = sat_sub(diff);
        res_code = diff[DATA_W] ? UNDERFLOW : SUCCESS;
      end
      INV: begin
        res_data = ~op1_q;
        res_code = SUCCESS;
      end
      default: begin
        res_data = '0;
        res_code = NO_RESPONSE;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    data_d  = data_q;
    resp_d  = NO_RESPONSE;
    case (state_q)
      IDLE: begin
        if (req_i.command != NOP) begin
          cmd_d   = req_i.command;
          op1_d   = req_i.data1;
          op2_d   = req_i.data2;
          cnt_d   = 4'd0;
          state_d = (LATENCY == 1) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESPOND: begin
        data_d  = res_data;
        resp_d  = res_code;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      resp_q  <= NO_RESPONSE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  end

  // Operand copies are only read after a capture, so they need no reset.
  always_ff @(posedge clk_i) begin
    cmd_q <= cmd_d;
    op1_q <= op1_d;
    op2_q <= op2_d;
  end

  assign rsp_o = '{data: data_q, response: resp_q};

endmodule

// File: rtl/alu.sv
// Multi-bank ALU top: NUM_BANKS independent alu_bank instances sharing clock and reset.
// ALU_SATURATE_EN selects saturating ADD/SUB results inside each bank.
module alu
  import alu_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int LATENCY   = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  input_packet_t  [NUM_BANKS-1:0] input_packet,
  output output_packet_t [NUM_BANKS-1:0] output_packet
);

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    alu_bank #(
      .LATENCY(LATENCY)
    ) u_bank (
      .clk_i (clock),
      .rst_ni(reset),
      .req_i (input_packet[g]),
      .rsp_o (output_packet[g])
    );
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard of expected responses (with arrival cycle) per bank.
// Honours ALU_SATURATE_EN for the expected ADD/SUB results.
module tb_alu;
  import alu_pkg::*;

  localparam int NB  = 4;
  localparam int LAT = 2;
`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0]     data;
    response_names_t resp;
    int              cyc;
  } ev_t;

  typedef struct {
    command_names_t  c;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     d;
    response_names_t r;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  input_packet_t  [NB-1:0] ip;
  output_packet_t [NB-1:0] op;

  ev_t exp_q[NB][$];
  ev_t obs_q[NB][$];
  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;

  always #5 clock = ~clock;

  alu #(
    .NUM_BANKS(NB),
    .LATENCY  (LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .input_packet (ip),
    .output_packet(op)
  );

  function automatic ev_t model(command_names_t c, logic [31:0] a, logic [31:0] b);
    ev_t e;
    logic [32:0] w;
    e.cyc = 0;
    case (c)
      ADD: begin
        w = {1'b0, a} + {1'b0, b};
        e.resp = w[32] ? OVERFLOW : SUCCESS;
        e.data = (w[32] && SAT) ? 32'hFFFF_FFFF : w[31:0];
      end
      SUB: begin
        e.resp = (b > a) ? UNDERFLOW : SUCCESS;
        e.data = ((b > a) && SAT) ? 32'h0 : a - b;
      end
      INV: begin
        e.resp = SUCCESS;
        e.data = ~a;
      end
      default: begin
        e.resp = NO_RESPONSE;
        e.data = 32'h0;
      end
    endcase
    return e;
  endfunction

  // One rising edge; record every non-idle response with the edge number it appeared at.
  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    for (int b = 0; b < NB; b++)
      if (op[b].response != NO_RESPONSE)
        obs_q[b].push_back('{op[b].data, op[b].response, cyc});
  endtask

  // Drive a command (call between edges) and expect one response per repeated capture.
  task automatic send(int b, command_names_t c, logic [31:0] a, logic [31:0] d, int reps);
    ev_t e;
    ip[b] = '{command: c, data1: a, data2: d};
    for (int k = 0; k < reps; k++) begin
      e = model(c, a, d);
      e.cyc = cyc + 1 + LAT + k * (LAT + 1);
      exp_q[b].push_back(e);
    end
  endtask

  task automatic all_nop();
    for (int b = 0; b < NB; b++) ip[b] = '{command: NOP, data1: 32'h0, data2: 32'h0};
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (op[b].data !== 32'h0 || op[b].response !== NO_RESPONSE) begin
        fails++;
        $display("FAIL reset_bank%0d: got data=%h resp=%0d, expected data=0 resp=0",
                 b, op[b].data, op[b].response);
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_add();
    int n;
    ev_t e, o;
    @(negedge clock);
    send(0, ADD, 32'd5, 32'd7, 1);
    n = cyc + 1;
    tick();
    @(negedge clock);
    all_nop();
    while (cyc < n + LAT) tick();
    tests++;
    if (op[0].data !== 32'd12 || op[0].response !== SUCCESS) begin
      fails++;
      $display("FAIL add_result: got data=%h resp=%0d, expected data=0000000c resp=1",
               op[0].data, op[0].response);
    end
    tick();
    tests++;
    if (op[0].data !== 32'd12 || op[0].response !== NO_RESPONSE) begin
      fails++;
      $display("FAIL add_hold: got data=%h resp=%0d, expected data=0000000c resp=0",
               op[0].data, op[0].response);
    end
    repeat (2) tick();
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (obs_q[b].size() != exp_q[b].size()) begin
        fails++;
        $display("FAIL add_count_bank%0d: got %0d responses, expected %0d",
                 b, obs_q[b].size(), exp_q[b].size());
      end
      while (exp_q[b].size() > 0 && obs_q[b].size() > 0) begin
        e = exp_q[b].pop_front();
        o = obs_q[b].pop_front();
        tests++;
        if (o.data !== e.data || o.resp !== e.resp || o.cyc !== e.cyc) begin
          fails++;
          $display("FAIL add_sb_bank%0d: got data=%h resp=%0d edge=%0d, expected data=%h resp=%0d edge=%0d",
                   b, o.data, o.resp, o.cyc, e.data, e.resp, e.cyc);
        end
      end
      exp_q[b].delete();
      obs_q[b].delete();
    end
  endtask

  task automatic test_arith_table();
    vec_t v[10];
    ev_t e, o;
    v[0] = '{ADD, 32'd5,         32'd7,         32'd12,                          SUCCESS};
    v[1] = '{ADD, 32'hFFFF_FFFF, 32'd2,         SAT ? 32'hFFFF_FFFF : 32'd1,     OVERFLOW};
    v[2] = '{ADD, 32'hFFFF_FFFF, 32'd1,         SAT ? 32'hFFFF_FFFF : 32'd0,     OVERFLOW};
    v[3] = '{ADD, 32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFF,                   SUCCESS};
    v[4] = '{SUB, 32'd3,         32'd5,         SAT ? 32'h0 : 32'hFFFF_FFFE,     UNDERFLOW};
    v[5] = '{SUB, 32'd9,         32'd4,         32'd5,                           SUCCESS};
    v[6] = '{SUB, 32'd7,         32'd7,         32'd0,                           SUCCESS};
    v[7] = '{SUB, 32'd0,         32'd1,         SAT ? 32'h0 : 32'hFFFF_FFFF,     UNDERFLOW};
    v[8] = '{INV, 32'h0F0F_0F0F, 32'h1234_5678, 32'hF0F0_F0F0,                   SUCCESS};
    v[9] = '{INV, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF,                   SUCCESS};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      send(0, v[i].c, v[i].a, v[i].b, 1);
      tick();
      @(negedge clock);
      all_nop();
      repeat (LAT) tick();
      tests++;
      if (op[0].data !== v[i].d || op[0].response !== v[i].r) begin
        fails++;
        $display("FAIL table_%0d: got data=%h resp=%0d, expected data=%h resp=%0d",
                 i, op[0].data, op[0].response, v[i].d, v[i].r);
      end
    end
    repeat (2) tick();
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (obs_q[b].size() != exp_q[b].size()) begin
        fails++;
        $display("FAIL table_count_bank%0d: got %0d responses, expected %0d",
                 b, obs_q[b].size(), exp_q[b].size());
      end
      while (exp_q[b].size() > 0 && obs_q[b].size() > 0) begin
        e = exp_q[b].pop_front();
        o = obs_q[b].pop_front();
        tests++;
        if (o.data !== e.data || o.resp !== e.resp || o.cyc !== e.cyc) begin
          fails++;
          $display("FAIL table_sb_bank%0d: got data=%h resp=%0d edge=%0d, expected data=%h resp=%0d edge=%0d",
                   b, o.data, o.resp, o.cyc, e.data, e.resp, e.cyc);
        end
      end
      exp_q[b].delete();
      obs_q[b].delete();
    end
  endtask

  task automatic test_concurrent();
    ev_t e, o;
    @(negedge clock);
    send(0, ADD, 32'd100,       32'd23,        1);
    send(1, INV, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 1);
    send(2, ADD, 32'h8000_0000, 32'h8000_0000, 1);
    send(3, ADD, 32'hFFFF_FFFF, 32'd3,         1);
    tick();
    for (int k = 0; k < LAT; k++) begin
      @(negedge clock);
      for (int b = 0; b < NB; b++)
        ip[b] = '{command: SUB, data1: $urandom, data2: $urandom};
      tick();
    end
    tests++;
    if (op[1].data !== 32'hF0F0_F0F0 || op[1].response !== SUCCESS) begin
      fails++;
      $display("FAIL conc_inv: got data=%h resp=%0d, expected data=f0f0f0f0 resp=1",
               op[1].data, op[1].response);
    end
    @(negedge clock);
    all_nop();
    repeat (LAT + 2) tick();
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (obs_q[b].size() != exp_q[b].size()) begin
        fails++;
        $display("FAIL conc_count_bank%0d: got %0d responses, expected %0d",
                 b, obs_q[b].size(), exp_q[b].size());
      end
      while (exp_q[b].size() > 0 && obs_q[b].size() > 0) begin
        e = exp_q[b].pop_front();
        o = obs_q[b].pop_front();
        tests++;
        if (o.data !== e.data || o.resp !== e.resp || o.cyc !== e.cyc) begin
          fails++;
          $display("FAIL conc_sb_bank%0d: got data=%h resp=%0d edge=%0d, expected data=%h resp=%0d edge=%0d",
                   b, o.data, o.resp, o.cyc, e.data, e.resp, e.cyc);
        end
      end
      exp_q[b].delete();
      obs_q[b].delete();
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    @(negedge clock);
    send(2, ADD, 32'd100, 32'd200, 3);
    send(3, SUB, 32'd1,   32'd2,   3);
    tick();
    repeat (2 * (LAT + 1)) tick();
    @(negedge clock);
    all_nop();
    repeat (LAT + 3) tick();
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (obs_q[b].size() != exp_q[b].size()) begin
        fails++;
        $display("FAIL b2b_count_bank%0d: got %0d responses, expected %0d",
                 b, obs_q[b].size(), exp_q[b].size());
      end
      while (exp_q[b].size() > 0 && obs_q[b].size() > 0) begin
        e = exp_q[b].pop_front();
        o = obs_q[b].pop_front();
        tests++;
        if (o.data !== e.data || o.resp !== e.resp || o.cyc !== e.cyc) begin
          fails++;
          $display("FAIL b2b_sb_bank%0d: got data=%h resp=%0d edge=%0d, expected data=%h resp=%0d edge=%0d",
                   b, o.data, o.resp, o.cyc, e.data, e.resp, e.cyc);
        end
      end
      exp_q[b].delete();
      obs_q[b].delete();
    end
  endtask

  task automatic test_reset_midop();
    ev_t e, o;
    @(negedge clock);
    ip[0] = '{command: ADD, data1: 32'd1, data2: 32'd2};
    tick();
    @(negedge clock);
    all_nop();
    tick();
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests++;
    if (op[0].data !== 32'h0 || op[0].response !== NO_RESPONSE) begin
      fails++;
      $display("FAIL midop_reset_async: got data=%h resp=%0d, expected data=0 resp=0",
               op[0].data, op[0].response);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if (obs_q[0].size() != 0) begin
      fails++;
      $display("FAIL midop_abort: got %0d responses, expected 0", obs_q[0].size());
    end
    @(negedge clock);
    send(0, SUB, 32'd50, 32'd8, 1);
    tick();
    @(negedge clock);
    all_nop();
    repeat (LAT + 2) tick();
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (obs_q[b].size() != exp_q[b].size()) begin
        fails++;
        $display("FAIL midop_count_bank%0d: got %0d responses, expected %0d",
                 b, obs_q[b].size(), exp_q[b].size());
      end
      while (exp_q[b].size() > 0 && obs_q[b].size() > 0) begin
        e = exp_q[b].pop_front();
        o = obs_q[b].pop_front();
        tests++;
        if (o.data !== e.data || o.resp !== e.resp || o.cyc !== e.cyc) begin
          fails++;
          $display("FAIL midop_sb_bank%0d: got data=%h resp=%0d edge=%0d, expected data=%h resp=%0d edge=%0d",
                   b, o.data, o.resp, o.cyc, e.data, e.resp, e.cyc);
        end
      end
      exp_q[b].delete();
      obs_q[b].delete();
    end
  endtask

  task automatic test_random();
    ev_t e, o;
    logic [31:0] a, d;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      for (int b = 0; b < NB; b++) begin
        a = $urandom;
        d = $urandom;
        if (i % 3 == 0) a = a | 32'hFF00_0000;
        send(b, command_names_t'(2'($urandom_range(3, 1))), a, d, 1);
      end
      tick();
      @(negedge clock);
      all_nop();
      repeat (LAT) tick();
    end
    repeat (2) tick();
    for (int b = 0; b < NB; b++) begin
      tests++;
      if (obs_q[b].size() != exp_q[b].size()) begin
        fails++;
        $display("FAIL rand_count_bank%0d: got %0d responses, expected %0d",
                 b, obs_q[b].size(), exp_q[b].size());
      end
      while (exp_q[b].size() > 0 && obs_q[b].size() > 0) begin
        e = exp_q[b].pop_front();
        o = obs_q[b].pop_front();
        tests++;
        if (o.data !== e.data || o.resp !== e.resp || o.cyc !== e.cyc) begin
          fails++;
          $display("FAIL rand_sb_bank%0d: got data=%h resp=%0d edge=%0d, expected data=%h resp=%0d edge=%0d",
                   b, o.data, o.resp, o.cyc, e.data, e.resp, e.cyc);
        end
      end
      exp_q[b].delete();
      obs_q[b].delete();
    end
  endtask

  initial begin
    all_nop();
    test_reset();
    test_add();
    test_arith_table();
    test_concurrent();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
